pipe_shifter: RTL and testbench
===============================

PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 Parameter DATA, default 32: data width, power of two, at least 4.
REQ-002 Parameter STAGES, default 2: register slices, 1..$clog2(DATA); the module SHALL error at elaboration outside this range.
REQ-003 Parameter BIT_VEC, default `DISABLE: when `ENABLE, shamt is a DATA-1 bit vector whose active-bit count is the shift amount; otherwise shamt is a $clog2(DATA)-bit binary index.
REQ-004 Parameter ACT, default `HIGH: active level counted when BIT_VEC is `ENABLE.
REQ-005 clk  input  1  the single clock.
REQ-006 reset_  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  request accepted this cycle when in_valid is also high.
REQ-009 in_data  input  DATA  operand.
REQ-010 in_shamt  input  SHW  shift amount, SHW = BIT_VEC ? DATA-1 : $clog2(DATA).
REQ-011 in_op  input  3  operation code (shift_op_t).
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_data  output  DATA  result.

Function
- REQ-015 Ops SHALL be: SL=0 logical left, SR=1 logical right, RL=2 rotate left, RR=3 rotate right, SRA=4 arithmetic right; codes 5-7 SHALL pass in_data through unchanged.
- REQ-016 The shift amount SHALL be decoded to binary n in 0..DATA-1 at input, before the first register; n=0 SHALL return in_data unchanged for every op.
- REQ-017 The $clog2(DATA) binary shift levels SHALL be split across STAGES slices, with ceil(levels/STAGES) levels in the earliest slices; each slice carries data, the remaining amount bits, op and a valid bit.
- REQ-018 Latency SHALL be exactly STAGES cycles from accept (in_valid & in_ready) to out_valid when no stall occurs.
- REQ-019 Pipeline enable en = out_ready | ~out_valid; all slices SHALL advance only when en is high, and in_ready SHALL equal en.
- REQ-020 Bubbles SHALL propagate as invalid slices and are not collapsed; throughput SHALL be one result per cycle while out_ready stays high.
- REQ-021 While out_valid & ~out_ready, out_data and out_valid SHALL hold stable and no input SHALL be accepted.
- REQ-022 Rotations SHALL wrap modulo DATA; SRA SHALL replicate in_data[DATA-1] into vacated bits.
- REQ-023 Results SHALL leave the pipeline in accept order, one per accepted request, with none dropped or duplicated.

Reset
- REQ-024 While reset_ is low, every slice valid and out_valid SHALL be 0 and out_data SHALL be 0, asynchronously.
- REQ-025 Reset mid-operation SHALL discard all in-flight requests; in_ready SHALL be 1 in the first cycle after reset release.

Configuration
- REQ-026 Macro PIPE_SHIFTER_SRA_EN: when defined, op 4 SHALL perform arithmetic right shift; when undefined, op 4 SHALL behave as SR and no sign-fill logic SHALL be synthesised.

Structure
- REQ-027 Package parammod_shift_pkg SHALL hold the shift_op_t enum (3-bit) and op code constants.
- REQ-028 Sub-module shift_stage SHALL implement one register slice: a combinational group of shift levels followed by an enabled register with asynchronous reset.
- REQ-029 For BIT_VEC decoding, the existing cnt_bits counter SHALL be reused.

Verification (DATA=8, STAGES=3, BIT_VEC off unless noted)
- REQ-030 SL 8'h81 by 1 -> 8'h02 after 3 cycles; RL 8'h81 by 1 -> 8'h03.
- REQ-031 RR 8'h01 by 7 -> 8'h02; SRA 8'h80 by 3 -> 8'hF0 with macro, 8'h10 without.
- REQ-032 Back-to-back: 8 requests on consecutive cycles with out_ready=1 -> 8 results on consecutive cycles, in order.
- REQ-033 Stall: hold out_ready=0 for 4 cycles with a full pipe -> out_data stable, in_ready=0, no loss after release.
- REQ-034 Assert reset_ low with 3 requests in flight -> out_valid=0 immediately, no stale result after release.
- REQ-035 BIT_VEC on, ACT `HIGH, shamt=7'b0010110, SR 8'hF0 -> 8'h1E.

Source files
------------

// File: rtl/parammod_shift_pkg.sv
// Shared operation codes for the pipelined barrel shifter, plus the
// ENABLE/DISABLE/HIGH/LOW literals used for its configuration parameters.
`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif

package parammod_shift_pkg;

    localparam int OP_W = 3;

    // Codes 5..7 are deliberately unnamed: they pass the operand through.
    typedef enum logic [OP_W-1:0] {
        OP_SL  = 3'd0,
        OP_SR  = 3'd1,
        OP_RL  = 3'd2,
        OP_RR  = 3'd3,
        OP_SRA = 3'd4
    } shift_op_t;

endpackage

// File: rtl/cnt_bits.sv
// Population counter: number of set bits in a W-bit vector.
module cnt_bits #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/shift_stage.sv
// One register slice of the shifter: shift levels FIRST..FIRST+CNT-1 then an
// enabled register. Arithmetic right shift only exists with PIPE_SHIFTER_SRA_EN.
module shift_stage
    import parammod_shift_pkg::*;
#(
    parameter int DATA  = 32,
    parameter int LW    = 5,
    parameter int FIRST = 0,
    parameter int CNT   = 1
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            en,
    input  logic            in_valid,
    input  logic [DATA-1:0] in_data,
    input  logic [LW-1:0]   in_amt,
    input  logic [OP_W-1:0] in_op,
    output logic            out_valid,
    output logic [DATA-1:0] out_data,
    output logic [LW-1:0]   out_amt,
    output logic [OP_W-1:0] out_op
);

    function automatic logic [DATA-1:0] shift_level(
        input logic [DATA-1:0] x,
        input logic [OP_W-1:0] op,
        input int unsigned     k
    );
        logic [DATA-1:0] r;
`ifdef PIPE_SHIFTER_SRA_EN
        logic signed [DATA-1:0] xs;
        xs = x;
`endif
        r = x;
        case (op)
            OP_SL:  r = x << k;
            OP_SR:  r = x >> k;
            OP_RL:  r = (x << k) | (x >> (DATA - k));
            OP_RR:  r = (x >> k) | (x << (DATA - k));
`ifdef PIPE_SHIFTER_SRA_EN
            OP_SRA: r = xs >>> k;
`else
            OP_SRA: r = x >> k;
`endif
            default: r = x;
        endcase
        return r;
    endfunction

    logic [DATA-1:0] nxt;

    always_comb begin
        nxt = in_data;
        for (int j = FIRST; j < FIRST + CNT; j++) begin
            if (in_amt[j]) begin
                nxt = shift_level(nxt, in_op, 2 ** j);
            end
        end
    end

    // ---- slice register boundary ----
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_op    <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= nxt;
            out_amt   <= in_amt;
            out_op    <= in_op;
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter with valid/ready handshake and STAGES register slices.
// Optional macro PIPE_SHIFTER_SRA_EN enables arithmetic right shift (op 4).
`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif
`ifndef HIGH
`define HIGH 1'b1
`endif

module pipe_shifter
    import parammod_shift_pkg::*;
#(
    parameter int DATA    = 32,
    parameter int STAGES  = 2,
    parameter bit BIT_VEC = `DISABLE,
    parameter bit ACT     = `HIGH,
    localparam int LEVELS = $clog2(DATA),
    localparam int SHW    = BIT_VEC ? DATA - 1 : LEVELS
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DATA-1:0] in_data,
    input  logic [SHW-1:0]  in_shamt,
    input  logic [2:0]      in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out_data
);

    if (DATA < 4 || (DATA & (DATA - 1)) != 0) begin : g_bad_data
        $error("pipe_shifter: DATA=%0d must be a power of two >= 4", DATA);
    end
    if (STAGES < 1 || STAGES > LEVELS) begin : g_bad_stages
        $error("pipe_shifter: STAGES=%0d outside 1..%0d", STAGES, LEVELS);
    end

    localparam int ST_SAFE = (STAGES < 1) ? 1 : STAGES;
    localparam int LV_BASE = LEVELS / ST_SAFE;
    localparam int LV_XTRA = LEVELS % ST_SAFE;

    logic            en;
    logic            vld_p  [STAGES+1];
    logic [DATA-1:0] data_p [STAGES+1];
    logic [LEVELS-1:0] amt_p [STAGES+1];
    logic [2:0]      op_p   [STAGES+1];
    logic            unused_tail;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // A stalled full pipe holds every slice, so nothing new can enter.
    assign vld_p[0]  = in_valid;
    assign data_p[0] = in_data;
    assign op_p[0]   = in_op;

    if (BIT_VEC) begin : g_bitvec
        logic [SHW-1:0] active_bits;
        assign active_bits = ACT ? in_shamt : ~in_shamt;
        cnt_bits #(
            .W  (SHW),
            .CW (LEVELS)
        ) u_cnt (
            .bits  (active_bits),
            .count (amt_p[0])
        );
    end else begin : g_binary
        assign amt_p[0] = in_shamt;
    end

    // Earliest slices take one extra level when levels do not divide evenly.
    for (genvar s = 0; s < STAGES; s++) begin : g_slice
        localparam int CNT   = LV_BASE + ((s < LV_XTRA) ? 1 : 0);
        localparam int FIRST = s * LV_BASE + ((s < LV_XTRA) ? s : LV_XTRA);
        shift_stage #(
            .DATA  (DATA),
            .LW    (LEVELS),
            .FIRST (FIRST),
            .CNT   (CNT)
        ) u_stage (
            .clk       (clk),
            .reset_    (reset_),
            .en        (en),
            .in_valid  (vld_p[s]),
            .in_data   (data_p[s]),
            .in_amt    (amt_p[s]),
            .in_op     (op_p[s]),
            .out_valid (vld_p[s+1]),
            .out_data  (data_p[s+1]),
            .out_amt   (amt_p[s+1]),
            .out_op    (op_p[s+1])
        );
    end

    assign out_valid   = vld_p[STAGES];
    assign out_data    = data_p[STAGES];
    assign unused_tail = ^{amt_p[STAGES], op_p[STAGES]};

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed bench for pipe_shifter with DATA=8, STAGES=3, plus a BIT_VEC instance.
`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef HIGH
`define HIGH 1'b1
`endif

module tb_pipe_shifter;
    import parammod_shift_pkg::*;

    logic       clk = 1'b0;
    logic       reset_;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [2:0] in_shamt, in_op;

    logic       bv_in_valid, bv_in_ready, bv_out_valid, bv_out_ready;
    logic [7:0] bv_in_data, bv_out_data;
    logic [6:0] bv_in_shamt;
    logic [2:0] bv_in_op;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef PIPE_SHIFTER_SRA_EN
    localparam logic [7:0] SRA_80_3 = 8'hF0;
    localparam logic [7:0] SRA_F1_7 = 8'hFF;
`else
    localparam logic [7:0] SRA_80_3 = 8'h10;
    localparam logic [7:0] SRA_F1_7 = 8'h01;
`endif

    always #5 clk = ~clk;

    pipe_shifter #(.DATA(8), .STAGES(3)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    pipe_shifter #(.DATA(8), .STAGES(3), .BIT_VEC(`ENABLE), .ACT(`HIGH)) dut_bv (
        .clk       (clk),
        .reset_    (reset_),
        .in_valid  (bv_in_valid),
        .in_ready  (bv_in_ready),
        .in_data   (bv_in_data),
        .in_shamt  (bv_in_shamt),
        .in_op     (bv_in_op),
        .out_valid (bv_out_valid),
        .out_ready (bv_out_ready),
        .out_data  (bv_out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic single(input string tag, input logic [2:0] op, input logic [7:0] d,
                          input logic [2:0] sh, input logic [7:0] exp);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 3);
        chk(tag, out_data, exp);
    endtask

    task automatic single_bv(input string tag, input logic [2:0] op, input logic [7:0] d,
                             input logic [6:0] sh, input logic [7:0] exp);
        int lat;
        @(negedge clk);
        bv_in_valid = 1'b1; bv_in_op = op; bv_in_data = d; bv_in_shamt = sh;
        @(negedge clk);
        bv_in_valid = 1'b0;
        lat = 1;
        while (!bv_out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 3);
        chk(tag, bv_out_data, exp);
    endtask

    initial begin
        reset_ = 1'b0;
        in_valid = 1'b1; in_op = OP_SL; in_data = 8'hFF; in_shamt = 3'd0; out_ready = 1'b1;
        bv_in_valid = 1'b1; bv_in_op = OP_SL; bv_in_data = 8'hFF; bv_in_shamt = '0;
        bv_out_ready = 1'b1;

        // Reset holds outputs clear even with requests presented
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_bv_out_valid", bv_out_valid, 0);
        in_valid = 1'b0; bv_in_valid = 1'b0;
        reset_ = 1'b1;
        #1 chk("rst_release_in_ready", in_ready, 1);

        // Directed single requests
        single("sl_81_1",   OP_SL,  8'h81, 3'd1, 8'h02);
        single("rl_81_1",   OP_RL,  8'h81, 3'd1, 8'h03);
        single("rr_01_7",   OP_RR,  8'h01, 3'd7, 8'h02);
        single("sra_80_3",  OP_SRA, 8'h80, 3'd3, SRA_80_3);
        single("sra_f1_7",  OP_SRA, 8'hF1, 3'd7, SRA_F1_7);
        single("sra_7f_2",  OP_SRA, 8'h7F, 3'd2, 8'h1F);
        single("sr_a5_0",   OP_SR,  8'hA5, 3'd0, 8'hA5);
        single("rl_a5_0",   OP_RL,  8'hA5, 3'd0, 8'hA5);
        single("op5_5a_3",  3'd5,   8'h5A, 3'd3, 8'h5A);
        single("op7_c3_1",  3'd7,   8'hC3, 3'd1, 8'hC3);
        single("sl_81_7",   OP_SL,  8'h81, 3'd7, 8'h80);
        single("sr_81_4",   OP_SR,  8'h81, 3'd4, 8'h08);
        single("rr_96_4",   OP_RR,  8'h96, 3'd4, 8'h69);
        single("rl_b4_6",   OP_RL,  8'hB4, 3'd6, 8'h2D);

        // Back-to-back: eight requests, eight consecutive in-order results
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k < 3) begin
                chk("b2b_bubble", out_valid, 0);
            end else begin
                chk("b2b_vld", out_valid, 1);
                chk("b2b_data", out_data, 8'h01 << (k - 3));
            end
            if (k < 8) begin
                in_valid = 1'b1; in_op = OP_SL; in_data = 8'h01; in_shamt = 3'(k);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_drained", out_valid, 0);

        // Stall with a full pipe, a fourth request waiting at the input
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = OP_SL; in_data = 8'h03; in_shamt = 3'(k + 1);
        end
        @(negedge clk);
        chk("stall_head_vld", out_valid, 1);
        chk("stall_head", out_data, 8'h06);
        out_ready = 1'b0;
        in_shamt = 3'd4;
        #1 chk("stall_in_ready0", in_ready, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_hold_data", out_data, 8'h06);
            chk("stall_hold_vld", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_r1", out_data, 8'h0C);
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_r2", out_data, 8'h18);
        @(negedge clk);
        chk("stall_r3", out_data, 8'h30);
        chk("stall_r3_vld", out_valid, 1);
        @(negedge clk);
        chk("stall_no_dup", out_valid, 0);

        // Bit-vector shift amounts
        single_bv("bv_sr_f0",  OP_SR, 8'hF0, 7'b0010110, 8'h1E);
        single_bv("bv_sl_01",  OP_SL, 8'h01, 7'b1111111, 8'h80);
        single_bv("bv_rr_81",  OP_RR, 8'h81, 7'b0000000, 8'h81);
        single_bv("bv_rl_81",  OP_RL, 8'h81, 7'b1000001, 8'h06);

        // Reset with three requests in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = OP_RL; in_data = 8'h11; in_shamt = 3'(k + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst_full", out_valid, 1);
        reset_ = 1'b0;
        #1;
        chk("midrst_vld_async", out_valid, 0);
        chk("midrst_data_async", out_data, 0);
        @(negedge clk);
        @(negedge clk);
        reset_ = 1'b1;
        #1 chk("midrst_in_ready", in_ready, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("midrst_no_stale", out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
